// File: rtl/instruction_fetch_buffer_pkg.sv
// Shared widths, defaults and the FIFO entry type for the instruction fetch buffer.
package fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int INSTR_W = 16;
  localparam int DEFAULT_DEPTH = 4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 8'h00;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Occupancy counters need one extra bit so that a full FIFO is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instruction_fetch_buffer_if.sv
// Bus bundle between the fetch buffer, the instruction memory and the decode/control FSM.
interface instruction_fetch_buffer_if #(
  parameter int LVL_W = fetch_pkg::level_w(fetch_pkg::DEFAULT_DEPTH)
);
  import fetch_pkg::*;

  logic               fetchEn;
  logic               imemRead;
  logic [ADDR_W-1:0]  imemAddr;
  logic [INSTR_W-1:0] imemData;
  logic               instrValid;
  logic               instrReady;
  logic [INSTR_W-1:0] instrOut;
  logic [ADDR_W-1:0]  instrPc;
  logic               redirect;
  logic [ADDR_W-1:0]  redirectPc;
  logic [LVL_W-1:0]   fifoLevel;

  modport master (
    input  fetchEn, imemData, instrReady, redirect, redirectPc,
    output imemRead, imemAddr, instrValid, instrOut, instrPc, fifoLevel
  );

  modport slave (
    output fetchEn, imemData, instrReady, redirect, redirectPc,
    input  imemRead, imemAddr, instrValid, instrOut, instrPc, fifoLevel
  );

endinterface

// File: rtl/instruction_fetch_buffer_fifo.sv
// Small register FIFO of {pc, instr} entries with flush; head entry readable without a pop.
module fetch_fifo #(
  parameter int DEPTH = fetch_pkg::DEFAULT_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  resetN,
  input  logic                                  flush_i,
  input  logic                                  push_i,
  input  fetch_pkg::fetch_entry_t               push_data_i,
  input  logic                                  pop_i,
  output fetch_pkg::fetch_entry_t               head_o,
  output logic [fetch_pkg::level_w(DEPTH)-1:0]  count_o
);
  import fetch_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = level_w(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Fetch stage: owns the fetch PC, issues 1-cycle-latency imem reads against FIFO credits,
// queues {pc, instr} for decode. Optional stall counter enabled by IFB_STALL_COUNT_EN.
module instruction_fetch_buffer #(
  parameter int                             DEPTH    = fetch_pkg::DEFAULT_DEPTH,
  parameter logic [fetch_pkg::ADDR_W-1:0]   RESET_PC = fetch_pkg::DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       resetN,
  instruction_fetch_buffer_if.master bus
`ifdef IFB_STALL_COUNT_EN
  ,
  output logic [15:0]                stallCount
`endif
);
  import fetch_pkg::*;

  localparam int LVL_W = level_w(DEPTH);
  localparam int SUM_W = LVL_W + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              in_flight_q, in_flight_d;
  logic              valid, pop, push, issue;
  logic [LVL_W-1:0]  count;
  logic [SUM_W-1:0]  credits_used;
  fetch_entry_t      head, push_entry;

  assign valid = (count != '0);
  assign pop   = valid & bus.instrReady;
  assign push  = in_flight_q & ~bus.redirect;

  // A slot is owed to every queued entry and to the read still in flight; a pop frees one now.
  assign credits_used = SUM_W'(count) + SUM_W'(in_flight_q) - SUM_W'(pop);
  assign issue = resetN & bus.fetchEn & ~bus.redirect & (credits_used < SUM_W'(DEPTH));

  assign push_entry = '{pc: tag_q, instr: bus.imemData};

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    tag_d       = tag_q;
    in_flight_d = 1'b0;
    if (bus.redirect) begin
      fetch_pc_d = bus.redirectPc;
    end else if (issue) begin
      fetch_pc_d  = fetch_pc_q + ADDR_W'(1);
      tag_d       = fetch_pc_q;
      in_flight_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fetch_pc_q  <= RESET_PC;
      tag_q       <= '0;
      in_flight_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      tag_q       <= tag_d;
      in_flight_q <= in_flight_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .resetN      (resetN),
    .flush_i     (bus.redirect),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.imemRead   = issue;
  assign bus.imemAddr   = fetch_pc_q;
  assign bus.instrValid = valid;
  assign bus.instrOut   = valid ? head.instr : '0;
  assign bus.instrPc    = valid ? head.pc : '0;
  assign bus.fifoLevel  = count;

`ifdef IFB_STALL_COUNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stall_q <= '0;
    end else if (!valid && bus.fetchEn && !bus.redirect && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stallCount = stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Self-checking bench for instruction_fetch_buffer: scoreboard of issued reads vs. popped entries.
module tb_instruction_fetch_buffer;

  logic clk = 1'b0;
  logic resetN;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_buffer_if #(.LVL_W(3)) bus ();

`ifdef IFB_STALL_COUNT_EN
  logic [15:0] stallCount;
`endif

  instruction_fetch_buffer #(.DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
`ifdef IFB_STALL_COUNT_EN
    ,
    .stallCount (stallCount)
`endif
  );

  // Synchronous instruction memory: word at address a holds 16'h1000 + a.
  always @(posedge clk) begin
    if (bus.imemRead) bus.imemData <= 16'h1000 + {8'h00, bus.imemAddr};
  end

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_pc;

  // Each issued read is expected to come out in order; a redirect or reset discards all of them.
  always @(negedge clk) begin
    exp_t e;
    if (!resetN) begin
      sb.delete();
      exp_pc = 8'h00;
    end else begin
      if (bus.instrValid && bus.instrReady) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_pop got pc=%02h instr=%04h want=<none>", bus.instrPc, bus.instrOut);
        end else begin
          e = sb.pop_front();
          if (bus.instrPc !== e.pc || bus.instrOut !== e.instr) begin
            errors++;
            $display("FAIL sb_entry got pc=%02h instr=%04h want pc=%02h instr=%04h",
                     bus.instrPc, bus.instrOut, e.pc, e.instr);
          end else begin
            $display("pop pc=%02h instr=%04h", bus.instrPc, bus.instrOut);
          end
        end
      end
      if (bus.redirect) begin
        checks++;
        if (bus.imemRead !== 1'b0) begin
          errors++;
          $display("FAIL sb_issue_on_redirect got=%b want=0", bus.imemRead);
        end
        sb.delete();
        exp_pc = bus.redirectPc;
      end else if (bus.imemRead) begin
        checks++;
        if (bus.imemAddr !== exp_pc) begin
          errors++;
          $display("FAIL sb_addr got=%02h want=%02h", bus.imemAddr, exp_pc);
        end
        sb.push_back('{pc: exp_pc, instr: 16'h1000 + {8'h00, exp_pc}});
        exp_pc = exp_pc + 8'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.fetchEn = 1'b1;
    bus.instrReady = 1'b1;
    bus.redirect = 1'b0;
    bus.redirectPc = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (bus.instrValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.instrValid); end
    checks++; if (bus.instrOut !== 16'h0) begin errors++; $display("FAIL reset_instr got=%04h want=0000", bus.instrOut); end
    checks++; if (bus.instrPc !== 8'h0) begin errors++; $display("FAIL reset_pc got=%02h want=00", bus.instrPc); end
    checks++; if (bus.imemRead !== 1'b0) begin errors++; $display("FAIL reset_read got=%b want=0", bus.imemRead); end
    checks++; if (bus.fifoLevel !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", bus.fifoLevel); end
    checks++; if (bus.imemAddr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%02h want=00", bus.imemAddr); end
`ifdef IFB_STALL_COUNT_EN
    checks++; if (stallCount !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d want=0", stallCount); end
`endif
    tick();
    resetN = 1'b1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (bus.imemRead !== 1'b1 || bus.imemAddr !== 8'(i)) begin
        errors++;
        $display("FAIL stream_issue cyc=%0d got read=%b addr=%02h want read=1 addr=%02h", i, bus.imemRead, bus.imemAddr, i);
      end
      checks++;
      if (bus.instrValid !== (i >= 2)) begin
        errors++;
        $display("FAIL stream_valid cyc=%0d got=%b want=%b", i, bus.instrValid, (i >= 2));
      end
`ifdef IFB_STALL_COUNT_EN
      if (i == 2) begin
        checks++;
        if (stallCount !== 16'd2) begin errors++; $display("FAIL stream_stall got=%0d want=2", stallCount); end
      end
`endif
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.fetchEn = 1'b0;
    bus.instrReady = 1'b1;
    #1;
    checks++; if (bus.imemRead !== 1'b0) begin errors++; $display("FAIL halt_read got=%b want=0", bus.imemRead); end
    repeat (8) tick();
    #1;
    checks++; if (bus.fifoLevel !== 3'd0) begin errors++; $display("FAIL drain_level got=%0d want=0", bus.fifoLevel); end
    bus.fetchEn = 1'b1;
    bus.instrReady = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.imemRead === 1'b1) n++;
      tick();
    end
    #1;
    checks++; if (n != 4) begin errors++; $display("FAIL full_issue_count got=%0d want=4", n); end
    checks++; if (bus.fifoLevel !== 3'd4) begin errors++; $display("FAIL full_level got=%0d want=4", bus.fifoLevel); end
    checks++; if (bus.imemRead !== 1'b0) begin errors++; $display("FAIL full_read got=%b want=0", bus.imemRead); end
    bus.instrReady = 1'b1;
    #1;
    checks++; if (bus.imemRead !== 1'b1) begin errors++; $display("FAIL full_resume got=%b want=1", bus.imemRead); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.instrValid !== 1'b1) begin
        errors++;
        $display("FAIL full_no_bubble cyc=%0d got=%b want=1", i, bus.instrValid);
      end
      tick();
      #1;
    end
  endtask

  task automatic test_redirect();
    bus.fetchEn = 1'b0;
    bus.instrReady = 1'b1;
    repeat (8) tick();
    bus.instrReady = 1'b0;
    bus.fetchEn = 1'b1;
    repeat (4) tick();
    #1;
    checks++; if (bus.fifoLevel !== 3'd3) begin errors++; $display("FAIL redir_pre_level got=%0d want=3", bus.fifoLevel); end
    bus.redirect = 1'b1;
    bus.redirectPc = 8'h40;
    tick();
    bus.redirect = 1'b0;
    bus.instrReady = 1'b1;
    #1;
    checks++; if (bus.fifoLevel !== 3'd0) begin errors++; $display("FAIL redir_level got=%0d want=0", bus.fifoLevel); end
    checks++; if (bus.instrValid !== 1'b0) begin errors++; $display("FAIL redir_valid got=%b want=0", bus.instrValid); end
    checks++;
    if (bus.imemRead !== 1'b1 || bus.imemAddr !== 8'h40) begin
      errors++;
      $display("FAIL redir_addr got read=%b addr=%02h want read=1 addr=40", bus.imemRead, bus.imemAddr);
    end
    tick();
    #1;
    checks++; if (bus.fifoLevel !== 3'd0) begin errors++; $display("FAIL redir_stale got=%0d want=0", bus.fifoLevel); end
    tick();
    #1;
    checks++;
    if (bus.instrValid !== 1'b1 || bus.instrPc !== 8'h40 || bus.instrOut !== 16'h1040) begin
      errors++;
      $display("FAIL redir_first got v=%b pc=%02h instr=%04h want v=1 pc=40 instr=1040",
               bus.instrValid, bus.instrPc, bus.instrOut);
    end
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    logic [7:0] want;
    bus.redirect = 1'b1;
    bus.redirectPc = 8'hFE;
    bus.fetchEn = 1'b1;
    bus.instrReady = 1'b1;
    tick();
    bus.redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      want = 8'hFE + 8'(i);
      #1;
      checks++;
      if (bus.imemRead !== 1'b1 || bus.imemAddr !== want) begin
        errors++;
        $display("FAIL wrap_addr cyc=%0d got read=%b addr=%02h want read=1 addr=%02h", i, bus.imemRead, bus.imemAddr, want);
      end
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic test_halt();
    bus.fetchEn = 1'b0;
    #1;
    checks++; if (bus.imemRead !== 1'b0) begin errors++; $display("FAIL halt0_read got=%b want=0", bus.imemRead); end
    checks++; if (bus.instrValid !== 1'b1) begin errors++; $display("FAIL halt0_valid got=%b want=1", bus.instrValid); end
    tick();
    #1;
    checks++; if (bus.imemRead !== 1'b0) begin errors++; $display("FAIL halt1_read got=%b want=0", bus.imemRead); end
    checks++; if (bus.instrValid !== 1'b1) begin errors++; $display("FAIL halt1_inflight got=%b want=1", bus.instrValid); end
    tick();
    #1;
    checks++; if (bus.instrValid !== 1'b0) begin errors++; $display("FAIL halt2_valid got=%b want=0", bus.instrValid); end
    checks++; if (bus.fifoLevel !== 3'd0) begin errors++; $display("FAIL halt2_level got=%0d want=0", bus.fifoLevel); end
    bus.redirect = 1'b1;
    bus.redirectPc = 8'h80;
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++;
    if (bus.imemRead !== 1'b0 || bus.imemAddr !== 8'h80) begin
      errors++;
      $display("FAIL halt_redir got read=%b addr=%02h want read=0 addr=80", bus.imemRead, bus.imemAddr);
    end
    tick();
    bus.fetchEn = 1'b1;
    #1;
    checks++;
    if (bus.imemRead !== 1'b1 || bus.imemAddr !== 8'h80) begin
      errors++;
      $display("FAIL halt_resume got read=%b addr=%02h want read=1 addr=80", bus.imemRead, bus.imemAddr);
    end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    bus.instrReady = 1'b0;
    tick();
    #1;
    checks++; if (bus.fifoLevel !== 3'd2) begin errors++; $display("FAIL rmid_pre_level got=%0d want=2", bus.fifoLevel); end
    resetN = 1'b0;
    #1;
    checks++; if (bus.instrValid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b want=0", bus.instrValid); end
    checks++; if (bus.instrOut !== 16'h0) begin errors++; $display("FAIL rmid_instr got=%04h want=0000", bus.instrOut); end
    checks++; if (bus.instrPc !== 8'h0) begin errors++; $display("FAIL rmid_pc got=%02h want=00", bus.instrPc); end
    checks++; if (bus.imemRead !== 1'b0) begin errors++; $display("FAIL rmid_read got=%b want=0", bus.imemRead); end
    checks++; if (bus.fifoLevel !== 3'd0) begin errors++; $display("FAIL rmid_level got=%0d want=0", bus.fifoLevel); end
    checks++; if (bus.imemAddr !== 8'h00) begin errors++; $display("FAIL rmid_addr got=%02h want=00", bus.imemAddr); end
`ifdef IFB_STALL_COUNT_EN
    checks++; if (stallCount !== 16'd0) begin errors++; $display("FAIL rmid_stall got=%0d want=0", stallCount); end
`endif
    tick();
    tick();
    resetN = 1'b1;
    bus.instrReady = 1'b1;
    #1;
    checks++;
    if (bus.imemRead !== 1'b1 || bus.imemAddr !== 8'h00) begin
      errors++;
      $display("FAIL rmid_restart got read=%b addr=%02h want read=1 addr=00", bus.imemRead, bus.imemAddr);
    end
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
